// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_1.sv
// Single-bit full adder cell used as the shared datapath of the serial adder.
module full_adder_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell stepped LSB-first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             busy_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow_out
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e           state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] a_next;
  logic             last_bit;

  full_adder_1 u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sum bits refill the vacated MSB of the A shift register, so it holds the sum after WIDTH steps.
  generate
    if (WIDTH == 1) begin : g_w1
      assign a_next = fa_sum;
    end else begin : g_wn
      assign a_next = {fa_sum, a_sr[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CntW'(WIDTH - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= StIdle;
      cnt           <= '0;
      a_sr          <= '0;
      b_sr          <= '0;
      carry         <= 1'b0;
      in_ready_out  <= 1'b1;
      out_valid_out <= 1'b0;
      sum_out       <= '0;
      carry_out     <= 1'b0;
      busy_out      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      overflow_out  <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid_in) begin
            a_sr         <= a_in;
            b_sr         <= b_in;
            carry        <= carry_in;
            cnt          <= '0;
            state        <= StRun;
            in_ready_out <= 1'b0;
            busy_out     <= 1'b1;
          end
        end
        StRun: begin
          a_sr  <= a_next;
          b_sr  <= b_sr >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            state         <= StDone;
            out_valid_out <= 1'b1;
            sum_out       <= a_next;
            carry_out     <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry flop holds the carry into the MSB during the last step
            overflow_out  <= carry ^ fa_cout;
`endif
          end
        end
        StDone: begin
          if (out_ready_in) begin
            state         <= StIdle;
            out_valid_out <= 1'b0;
            in_ready_out  <= 1'b1;
            busy_out      <= 1'b0;
          end
        end
        default: begin
          state         <= StIdle;
          out_valid_out <= 1'b0;
          in_ready_out  <= 1'b1;
          busy_out      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8), overflow checked when enabled.
module tb_serial_adder_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       in_valid_in;
  logic       in_ready_out;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       carry_in;
  logic       out_valid_out;
  logic       out_ready_in;
  logic [7:0] sum_out;
  logic       carry_out;
  logic       busy_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic       overflow_out;
`endif

  int total = 0;
  int bad   = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (in_ready_out),
    .a_in          (a_in),
    .b_in          (b_in),
    .carry_in      (carry_in),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in),
    .sum_out       (sum_out),
    .carry_out     (carry_out),
    .busy_out      (busy_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow_out  (overflow_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq(tag, 64'(overflow_out), 64'(exp));
`endif
  endtask

  // Full operation with consumer always ready, including latency and return-to-idle checks.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic ec, input logic eo);
    out_ready_in = 1'b1;
    a_in = a;
    b_in = b;
    carry_in = cin;
    in_valid_in = 1'b1;
    check_eq({tag, " ready_pre"}, 64'(in_ready_out), 64'd1);
    step();
    in_valid_in = 1'b0;
    check_eq({tag, " busy"}, 64'(busy_out), 64'd1);
    repeat (7) step();
    check_eq({tag, " not_early"}, 64'(out_valid_out), 64'd0);
    step();
    check_eq({tag, " valid"}, 64'(out_valid_out), 64'd1);
    check_eq({tag, " sum"}, 64'(sum_out), 64'(es));
    check_eq({tag, " carry"}, 64'(carry_out), 64'(ec));
    check_ovf({tag, " ovf"}, eo);
    step();
    check_eq({tag, " idle_valid"}, 64'(out_valid_out), 64'd0);
    check_eq({tag, " idle_ready"}, 64'(in_ready_out), 64'd1);
  endtask

  initial begin
    bit saw_valid;
    rst_in = 1'b1;
    in_valid_in = 1'b0;
    out_ready_in = 1'b0;
    a_in = '0;
    b_in = '0;
    carry_in = 1'b0;
    step();
    step();
    rst_in = 1'b0;
    check_eq("rst ready", 64'(in_ready_out), 64'd1);
    check_eq("rst valid", 64'(out_valid_out), 64'd0);
    check_eq("rst sum", 64'(sum_out), 64'd0);
    check_eq("rst carry", 64'(carry_out), 64'd0);
    check_eq("rst busy", 64'(busy_out), 64'd0);
    check_ovf("rst ovf", 1'b0);

    run_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("55+2a+1", 8'h55, 8'h2A, 1'b1, 8'h80, 1'b0, 1'b1);

    // Backpressure: result must hold for 5 stalled cycles.
    out_ready_in = 1'b0;
    a_in = 8'h0F;
    b_in = 8'hF0;
    carry_in = 1'b1;
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    repeat (8) step();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp valid", 64'(out_valid_out), 64'd1);
      check_eq("bp sum", 64'(sum_out), 64'h00);
      check_eq("bp carry", 64'(carry_out), 64'd1);
      check_eq("bp ready_low", 64'(in_ready_out), 64'd0);
      step();
    end
    out_ready_in = 1'b1;
    step();
    check_eq("bp idle_valid", 64'(out_valid_out), 64'd0);
    check_eq("bp idle_ready", 64'(in_ready_out), 64'd1);
    check_eq("bp idle_busy", 64'(busy_out), 64'd0);

    // New operands offered mid-RUN must be ignored.
    a_in = 8'h12;
    b_in = 8'h34;
    carry_in = 1'b0;
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    repeat (3) step();
    a_in = 8'hFF;
    b_in = 8'hFF;
    carry_in = 1'b1;
    in_valid_in = 1'b1;
    check_eq("run ready_low", 64'(in_ready_out), 64'd0);
    step();
    in_valid_in = 1'b0;
    repeat (4) step();
    check_eq("ign valid", 64'(out_valid_out), 64'd1);
    check_eq("ign sum", 64'(sum_out), 64'h46);
    check_eq("ign carry", 64'(carry_out), 64'd0);
    step();
    check_eq("ign idle", 64'(in_ready_out), 64'd1);

    // Reset at RUN cycle 3 aborts with no result.
    a_in = 8'hAA;
    b_in = 8'h55;
    carry_in = 1'b0;
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    step();
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check_eq("abort ready", 64'(in_ready_out), 64'd1);
    check_eq("abort valid", 64'(out_valid_out), 64'd0);
    check_eq("abort sum", 64'(sum_out), 64'd0);
    check_eq("abort carry", 64'(carry_out), 64'd0);
    check_eq("abort busy", 64'(busy_out), 64'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid_out) saw_valid = 1'b1;
      step();
    end
    check_eq("abort no_result", 64'(saw_valid), 64'd0);

    // Back-to-back with in_valid held high.
    out_ready_in = 1'b1;
    a_in = 8'd3;
    b_in = 8'd4;
    carry_in = 1'b0;
    in_valid_in = 1'b1;
    step();
    a_in = 8'd200;
    b_in = 8'd100;
    repeat (8) step();
    check_eq("b2b1 valid", 64'(out_valid_out), 64'd1);
    check_eq("b2b1 sum", 64'(sum_out), 64'd7);
    check_eq("b2b1 carry", 64'(carry_out), 64'd0);
    step();
    check_eq("b2b gap_ready", 64'(in_ready_out), 64'd1);
    check_eq("b2b gap_busy", 64'(busy_out), 64'd0);
    step();
    in_valid_in = 1'b0;
    check_eq("b2b2 accepted", 64'(busy_out), 64'd1);
    repeat (7) step();
    check_eq("b2b2 not_early", 64'(out_valid_out), 64'd0);
    step();
    check_eq("b2b2 valid", 64'(out_valid_out), 64'd1);
    check_eq("b2b2 sum", 64'(sum_out), 64'd44);
    check_eq("b2b2 carry", 64'(carry_out), 64'd1);
    check_ovf("b2b2 ovf", 1'b0);
    step();
    check_eq("b2b2 done", 64'(out_valid_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
